// File: rtl/ase_ccip_buf_pkg.sv
// rtl/ase_ccip_buf_pkg.sv - shared defaults, entry type and sizing helper for CCI-P buffers
package ase_ccip_buf_pkg;

    localparam int C1_DEPTH_DEF         = 16;
    localparam int C1_ALMFULL_SLACK_DEF = 4;
    localparam int C1_HDR_W             = 80;
    localparam int C1_DATA_W            = 512;

    typedef struct packed {
        logic [C1_HDR_W-1:0]  hdr;
        logic [C1_DATA_W-1:0] data;
    } t_c1_entry;

    // Occupancy counts 0..depth inclusive, so it needs one bit beyond the pointer.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ase_sync_fifo_ram.sv
// rtl/ase_sync_fifo_ram.sv - circular-buffer storage with wrapping pointers and occupancy count
module ase_sync_fifo_ram
    import ase_ccip_buf_pkg::*;
#(
    parameter int DEPTH = C1_DEPTH_DEF,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int OW   = occ_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [OW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Contents are never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ccip_c1_tx_buffer.sv
// rtl/ccip_c1_tx_buffer.sv - elastic C1 write-request buffer; ASE_C1_TX_BUFFER_STATS_EN adds stats
module ccip_c1_tx_buffer
    import ase_ccip_buf_pkg::*;
#(
    parameter int DEPTH         = C1_DEPTH_DEF,
    parameter int ALMFULL_SLACK = C1_ALMFULL_SLACK_DEF,
    parameter int HDR_W         = C1_HDR_W,
    parameter int DATA_W        = C1_DATA_W
) (
    input  logic                     vl_clk_LPdomain_16ui,
    input  logic                     ffs_LP16ui_afu_SoftReset_n,
    input  logic                     afu_c1_valid,
    input  logic [HDR_W-1:0]         afu_c1_hdr,
    input  logic [DATA_W-1:0]        afu_c1_data,
    output logic                     afu_c1_almfull,
    input  logic                     emu_c1_almfull,
    output logic                     emu_c1_valid,
    output logic [HDR_W-1:0]         emu_c1_hdr,
    output logic [DATA_W-1:0]        emu_c1_data,
    output logic                     ovf_error,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef ASE_C1_TX_BUFFER_STATS_EN
    ,
    output logic [31:0]              stat_push_cnt,
    output logic [31:0]              stat_pop_cnt,
    output logic [$clog2(DEPTH):0]   stat_max_occ,
    output logic [31:0]              stat_stall_cyc
`endif
);

    localparam int OW = occ_width(DEPTH);
    localparam int EW = HDR_W + DATA_W;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic          pop;
    logic          full;
    logic [EW-1:0] head;
    logic [OW-1:0] next_occ;

    assign clk   = vl_clk_LPdomain_16ui;
    assign rst_n = ffs_LP16ui_afu_SoftReset_n;

    // Pop looks only at registered occupancy, so a push into an empty buffer is never bypassed.
    assign pop      = (occupancy != '0) && !emu_c1_almfull;
    assign full     = (occupancy == OW'(DEPTH));
    assign push     = afu_c1_valid && (!full || pop);
    assign next_occ = occupancy + OW'(push) - OW'(pop);

    ase_sync_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({afu_c1_hdr, afu_c1_data}),
        .rdata (head),
        .count (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afu_c1_almfull <= 1'b0;
            emu_c1_valid   <= 1'b0;
            emu_c1_hdr     <= '0;
            emu_c1_data    <= '0;
            ovf_error      <= 1'b0;
        end else begin
            afu_c1_almfull <= (OW'(DEPTH) - next_occ) <= OW'(ALMFULL_SLACK);
            emu_c1_valid   <= pop;
            if (pop) begin
                emu_c1_hdr  <= head[EW-1:DATA_W];
                emu_c1_data <= head[DATA_W-1:0];
            end
            if (afu_c1_valid && full && !pop) begin
                ovf_error <= 1'b1;
            end
        end
    end

`ifdef ASE_C1_TX_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_push_cnt  <= '0;
            stat_pop_cnt   <= '0;
            stat_max_occ   <= '0;
            stat_stall_cyc <= '0;
        end else begin
            if (push && (stat_push_cnt != '1)) begin
                stat_push_cnt <= stat_push_cnt + 1'b1;
            end
            if (pop && (stat_pop_cnt != '1)) begin
                stat_pop_cnt <= stat_pop_cnt + 1'b1;
            end
            if ((occupancy != '0) && emu_c1_almfull && (stat_stall_cyc != '1)) begin
                stat_stall_cyc <= stat_stall_cyc + 1'b1;
            end
            if (occupancy > stat_max_occ) begin
                stat_max_occ <= occupancy;
            end
        end
    end

    final begin
        $display("ccip_c1_tx_buffer stats: push=%0d pop=%0d max_occ=%0d stall=%0d",
                 stat_push_cnt, stat_pop_cnt, stat_max_occ, stat_stall_cyc);
    end
`endif

endmodule
